// File: rtl/jtag_shift_engine.sv
// Host-driven JTAG shift engine: shifts up to 32 TMS/TDI pairs LSB-first at a divided TCK.
// Optional feature macro: JTAG_ENGINE_TLR_EN (adds CMD_TLR one-shot Test-Logic-Reset command).
module jtag_shift_engine #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned NUM_CHAINS  = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [31:0] CMD_TMS,
  input  logic [31:0] CMD_TDI,
  input  logic [5:0]  CMD_LEN,
  input  logic [3:0]  CMD_SEL,
`ifdef JTAG_ENGINE_TLR_EN
  input  logic        CMD_TLR,
`endif
  output logic        RSP_VALID,
  output logic [31:0] RSP_TDO,
  output logic        RSP_ERR,
  output logic [3:0]  JTAG_SEL,
  output logic        V_TCK,
  output logic        V_TMS,
  output logic        V_TDI,
  input  logic        V_TDO
);

  localparam int unsigned DivW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     tms_q, tms_d, tdi_q, tdi_d, cap_q, cap_d;
  logic [5:0]      len_q, len_d;
  logic [4:0]      bit_q, bit_d;
  logic [DivW-1:0] div_q, div_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_tdo_q, rsp_tdo_d;
  logic            rsp_err_q, rsp_err_d;
  logic [3:0]      sel_q, sel_d;
  logic            tck_q, tck_d, vtms_q, vtms_d, vtdi_q, vtdi_d;

  logic [31:0] tms_in, tdi_in;
  logic [5:0]  len_in;
  logic        sel_bad, div_last, bit_last;
  logic [4:0]  bit_nxt;

  always_comb begin
    state_d     = state_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cap_d       = cap_q;
    len_d       = len_q;
    bit_d       = bit_q;
    div_d       = div_q;
    err_d       = err_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_tdo_d   = rsp_tdo_q;
    rsp_err_d   = rsp_err_q;
    sel_d       = sel_q;
    tck_d       = tck_q;
    vtms_d      = vtms_q;
    vtdi_d      = vtdi_q;

    tms_in = CMD_TMS;
    tdi_in = CMD_TDI;
    len_in = (CMD_LEN > 6'd32) ? 6'd32 : CMD_LEN;
`ifdef JTAG_ENGINE_TLR_EN
    if (CMD_TLR) begin
      tms_in = 32'h0000_001F;
      tdi_in = '0;
      len_in = 6'd5;
    end
`endif
    sel_bad  = 32'(CMD_SEL) >= NUM_CHAINS;
    div_last = (div_q == DivLast);
    bit_last = ({1'b0, bit_q} == (len_q - 6'd1));
    bit_nxt  = bit_q + 5'd1;

    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          ready_d = 1'b0;
          tms_d   = tms_in;
          tdi_d   = tdi_in;
          len_d   = len_in;
          bit_d   = '0;
          div_d   = '0;
          cap_d   = '0;
          err_d   = sel_bad;
          if (sel_bad) begin
            state_d = StDone;
          end else begin
            sel_d = CMD_SEL;
            if (len_in == 6'd0) begin
              state_d = StDone;
            end else begin
              state_d = StLow;
              vtms_d  = tms_in[0];
              vtdi_d  = tdi_in[0];
            end
          end
        end
      end
      StLow: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d        = '0;
          state_d      = StHigh;
          tck_d        = 1'b1;
          cap_d[bit_q] = V_TDO;
        end
      end
      StHigh: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d = '0;
          tck_d = 1'b0;
          if (bit_last) begin
            state_d = StDone;
          end else begin
            // TMS/TDI move only together with the falling TCK edge.
            bit_d   = bit_nxt;
            state_d = StLow;
            vtms_d  = tms_q[bit_nxt];
            vtdi_d  = tdi_q[bit_nxt];
          end
        end
      end
      StDone: begin
        rsp_valid_d = 1'b1;
        rsp_tdo_d   = cap_q;
        rsp_err_d   = err_q;
        ready_d     = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      tms_q       <= '0;
      tdi_q       <= '0;
      cap_q       <= '0;
      len_q       <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= '0;
      rsp_err_q   <= 1'b0;
      sel_q       <= '0;
      tck_q       <= 1'b0;
      vtms_q      <= 1'b1;
      vtdi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cap_q       <= cap_d;
      len_q       <= len_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
      rsp_err_q   <= rsp_err_d;
      sel_q       <= sel_d;
      tck_q       <= tck_d;
      vtms_q      <= vtms_d;
      vtdi_q      <= vtdi_d;
    end
  end

  assign CMD_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_TDO   = rsp_tdo_q;
  assign RSP_ERR   = rsp_err_q;
  assign JTAG_SEL  = sel_q;
  assign V_TCK     = tck_q;
  assign V_TMS     = vtms_q;
  assign V_TDI     = vtdi_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench for jtag_shift_engine: vector table plus reset-abort, busy-ignore and TLR cases.
module tb_jtag_shift_engine;

  localparam int HP = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [31:0] CMD_TMS = '0;
  logic [31:0] CMD_TDI = '0;
  logic [5:0]  CMD_LEN = '0;
  logic [3:0]  CMD_SEL = '0;
`ifdef JTAG_ENGINE_TLR_EN
  logic        CMD_TLR = 1'b0;
`endif
  logic        RSP_VALID;
  logic [31:0] RSP_TDO;
  logic        RSP_ERR;
  logic [3:0]  JTAG_SEL;
  logic        V_TCK, V_TMS, V_TDI, V_TDO;
  logic        tdo_inv = 1'b0;

  assign V_TDO = tdo_inv ? ~V_TDI : V_TDI;

  jtag_shift_engine #(.HALF_PERIOD(HP), .NUM_CHAINS(12)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TMS(CMD_TMS), .CMD_TDI(CMD_TDI), .CMD_LEN(CMD_LEN), .CMD_SEL(CMD_SEL),
`ifdef JTAG_ENGINE_TLR_EN
    .CMD_TLR(CMD_TLR),
`endif
    .RSP_VALID(RSP_VALID), .RSP_TDO(RSP_TDO), .RSP_ERR(RSP_ERR), .JTAG_SEL(JTAG_SEL),
    .V_TCK(V_TCK), .V_TMS(V_TMS), .V_TDI(V_TDI), .V_TDO(V_TDO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int tms0_rises = 0;
  int tdi1_rises = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge V_TCK) begin
    rises++;
    if (V_TMS == 1'b0) tms0_rises++;
    if (V_TDI == 1'b1) tdi1_rises++;
  end

  // Per-cycle protocol monitor: TMS/TDI stable while TCK high, phase lengths equal HP.
  logic chk_off = 1'b1;
  logic prev_tck, prev_tms, prev_tdi, prev_ready;
  int   run = 1;
  bit   armed = 1'b0;

  always @(negedge CLK) begin
    if (chk_off) begin
      armed = 1'b0;
      run   = 1;
    end else begin
      if (V_TCK && prev_tck) begin
        checks++;
        if (V_TMS !== prev_tms || V_TDI !== prev_tdi) begin
          errors++;
          $display("FAIL tms_tdi_stable: tms %b->%b tdi %b->%b while tck high",
                   prev_tms, V_TMS, prev_tdi, V_TDI);
        end
      end
      if (prev_ready && !CMD_READY) begin
        run   = 1;
        armed = 1'b1;
      end else if (V_TCK !== prev_tck) begin
        if (prev_tck || armed) begin
          checks++;
          if (run != HP) begin
            errors++;
            $display("FAIL tck_phase: %s phase lasted %0d expected %0d",
                     prev_tck ? "high" : "low", run, HP);
          end
        end
        armed = prev_tck;
        run   = 1;
      end else begin
        run++;
      end
      if (CMD_READY) armed = 1'b0;
    end
    prev_tck   = V_TCK;
    prev_tms   = V_TMS;
    prev_tdi   = V_TDI;
    prev_ready = CMD_READY;
  end

  typedef struct {
    logic [3:0]  sel;
    logic [5:0]  len;
    logic [31:0] tms;
    logic [31:0] tdi;
    logic        inv;
    logic        poke;
    logic        exp_err;
    logic [31:0] exp_tdo;
    int          exp_rises;
    int          exp_lat;
    logic [3:0]  exp_sel;
    logic        chk_tms;
    logic        exp_tms;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_rsp(output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (RSP_VALID) got = 1'b1;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    bit got;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge CLK);
    chk({tag, "_ready"}, 32'(CMD_READY), 32'd1);
    tdo_inv   = v.inv;
    CMD_SEL   = v.sel;
    CMD_LEN   = v.len;
    CMD_TMS   = v.tms;
    CMD_TDI   = v.tdi;
    CMD_VALID = 1'b1;
    rises     = 0;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (v.poke && cyc == 2) begin
        CMD_VALID = 1'b1;
        CMD_SEL   = 4'd9;
        CMD_LEN   = 6'd1;
      end
      if (v.poke && cyc == 4) CMD_VALID = 1'b0;
      if (RSP_VALID) got = 1'b1;
    end
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({tag, "_rsp_tdo"}, RSP_TDO, v.exp_tdo);
    chk({tag, "_rsp_err"}, 32'(RSP_ERR), 32'(v.exp_err));
    chk({tag, "_tck_rises"}, 32'(rises), 32'(v.exp_rises));
    chk({tag, "_jtag_sel"}, 32'(JTAG_SEL), 32'(v.exp_sel));
    if (v.chk_tms) chk({tag, "_tms_hold"}, 32'(V_TMS), 32'(v.exp_tms));
    @(posedge CLK);
    #1;
    chk({tag, "_rsp_pulse"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_ready_after"}, 32'(CMD_READY), 32'd1);
    chk({tag, "_tdo_held"}, RSP_TDO, v.exp_tdo);
  endtask

  initial begin
    int  cyc;
    int  pulses;
    bit  got;

    //          sel    len     tms           tdi           inv   poke  err   tdo          r   lat  jsel  ct   tms
    vecs[0] = '{4'd3,  6'd8,  32'h0000_0080, 32'hCCCC_00A5, 1'b0, 1'b0, 1'b0, 32'h0000_00A5, 8,  65,  4'd3,  1'b1, 1'b1};
    vecs[1] = '{4'd12, 6'd8,  32'h0000_00FF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 0,  1,   4'd3,  1'b0, 1'b0};
    vecs[2] = '{4'd7,  6'd0,  32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 0,  1,   4'd7,  1'b0, 1'b0};
    vecs[3] = '{4'd11, 6'd40, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32, 257, 4'd11, 1'b1, 1'b0};
    vecs[4] = '{4'd1,  6'd5,  32'h0000_0010, 32'h0000_0015, 1'b1, 1'b1, 1'b0, 32'h0000_000A, 5,  41,  4'd1,  1'b1, 1'b1};
    vecs[5] = '{4'd15, 6'd3,  32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 0,  1,   4'd1,  1'b0, 1'b0};
    vecs[6] = '{4'd0,  6'd1,  32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1,  9,   4'd0,  1'b1, 1'b0};
    vecs[7] = '{4'd2,  6'd32, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h2152_4110, 32, 257, 4'd2,  1'b1, 1'b1};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_tdo", RSP_TDO, 32'd0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_jtag_sel", 32'(JTAG_SEL), 32'd0);
    chk("rst_tck", 32'(V_TCK), 32'd0);
    chk("rst_tms", 32'(V_TMS), 32'd1);
    chk("rst_tdi", 32'(V_TDI), 32'd0);
    chk_off = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Abort a 32-bit shift with reset around bit 10.
    @(negedge CLK);
    tdo_inv   = 1'b0;
    CMD_SEL   = 4'd5;
    CMD_LEN   = 6'd32;
    CMD_TMS   = 32'h0000_0000;
    CMD_TDI   = 32'hF0F0_F0F0;
    CMD_VALID = 1'b1;
    rises     = 0;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    cyc = 0;
    while (rises < 10 && cyc < 500) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk("abort_reached_bit10", 32'(rises), 32'd10);
    chk("abort_sel_before", 32'(JTAG_SEL), 32'd5);
    @(negedge CLK);
    chk_off = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_tck", 32'(V_TCK), 32'd0);
    chk("abort_tms", 32'(V_TMS), 32'd1);
    chk("abort_jtag_sel", 32'(JTAG_SEL), 32'd0);
    chk("abort_ready", 32'(CMD_READY), 32'd1);
    chk("abort_rsp_valid", 32'(RSP_VALID), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    pulses = 0;
    repeat (300) begin
      @(posedge CLK);
      #1;
      if (RSP_VALID) pulses++;
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    chk("abort_no_more_tck", 32'(rises), 32'd10);
    @(negedge CLK);
    chk_off = 1'b0;

    run_vec(8, vecs[0]);

`ifdef JTAG_ENGINE_TLR_EN
    @(negedge CLK);
    tdo_inv    = 1'b1;
    CMD_SEL    = 4'd0;
    CMD_LEN    = 6'd3;
    CMD_TMS    = 32'h0000_0000;
    CMD_TDI    = 32'hFFFF_FFFF;
    CMD_TLR    = 1'b1;
    CMD_VALID  = 1'b1;
    rises      = 0;
    tms0_rises = 0;
    tdi1_rises = 0;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_TLR   = 1'b0;
    wait_rsp(cyc, got);
    chk("tlr_rsp_seen", 32'(got), 32'd1);
    chk("tlr_latency", 32'(cyc), 32'd41);
    chk("tlr_rises", 32'(rises), 32'd5);
    chk("tlr_tms_low_rises", 32'(tms0_rises), 32'd0);
    chk("tlr_tdi_high_rises", 32'(tdi1_rises), 32'd0);
    chk("tlr_rsp_tdo", RSP_TDO, 32'h0000_001F);
    chk("tlr_rsp_err", 32'(RSP_ERR), 32'd0);
`endif

    repeat (4) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
